unidade_controle: RTL and testbench

Multicycle control unit and instruction register for the RV32I-subset datapath. Latches the fetched instruction, steps the multicycle state sequence and drives the `state`, `pcsrc`, `immediate` and `negative` signals consumed directly by the PC-update stage, plus the datapath enables. It sits upstream of the PC-update stage and closes the loop: the PC that stage produces addresses the instruction memory whose output returns here as `instr`.

---
 rtl/controle_pkg.sv | 32 +++
 rtl/gerador_imediato.sv | 23 ++
 rtl/unidade_controle.sv | 138 +++++++++++++
 tb/tb_unidade_controle.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/controle_pkg.sv
// rtl/controle_pkg.sv - state encodings, opcodes and ALU op codes for the multicycle control unit
package controle_pkg;

    localparam int STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = 4'b0000,
        S_DECODE = 4'b0001,
        S_EXEC   = 4'b0010,
        S_MEM    = 4'b0100,
        S_WB     = 4'b0110,
        S_PCUPD  = 4'b1000,
        S_HALT   = 4'b1111
    } state_e;

    localparam logic [6:0] OP_LW = 7'b0000011;
    localparam logic [6:0] OP_SW = 7'b0100011;
    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_RTYPE = 2'b10;
    localparam logic [1:0] ALU_ITYPE = 2'b11;

    // Reassembles the 13-bit signed B-type byte offset (bit 0 always 0).
    function automatic logic [12:0] b_offset(input logic [31:0] ir);
        return {ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/gerador_imediato.sv
// rtl/gerador_imediato.sv - splits the B-type branch offset into sign and magnitude
module gerador_imediato
    import controle_pkg::*;
(
    input  logic [31:0] ir_i,
    output logic        negative_o,
    output logic [11:0] magnitude_o,
    output logic        overflow_o
);

    logic [12:0] offset;
    logic [12:0] mag;
    logic        unused_bits;

    assign offset      = b_offset(ir_i);
    assign mag         = offset[12] ? (~offset + 13'd1) : offset;
    assign negative_o  = offset[12];
    assign magnitude_o = mag[11:0];
    // -4096 is the only offset whose magnitude does not fit in 12 bits
    assign overflow_o  = (offset == 13'h1000);
    assign unused_bits = ^{ir_i[24:12], ir_i[6:0], mag[12]};

endmodule

// File: rtl/unidade_controle.sv
// rtl/unidade_controle.sv - multicycle control unit and instruction register
module unidade_controle
    import controle_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [31:0]        instr,
    input  logic               zero,
    output logic [STATE_W-1:0] state,
    output logic [31:0]        ir,
    output logic               pcsrc,
    output logic [11:0]        immediate,
    output logic               negative,
    output logic               reg_write,
    output logic               mem_read,
    output logic               mem_write,
    output logic               alu_src,
    output logic               mem_to_reg,
    output logic [1:0]         alu_op,
    output logic               illegal,
    output logic [31:0]        retired
);

    state_e      state_q;
    logic [31:0] ir_q;
    logic        pcsrc_q;
    logic [11:0] imm_q;
    logic        neg_q;
    logic        illegal_q;
    logic [31:0] retired_q;

    logic        g_neg;
    logic [11:0] g_mag;
    logic        g_ovf;

    gerador_imediato u_gerador_imediato (
        .ir_i        (ir_q),
        .negative_o  (g_neg),
        .magnitude_o (g_mag),
        .overflow_o  (g_ovf)
    );

    logic [6:0] opcode;
    logic       is_lw, is_sw, is_r, is_i, is_br, br_ok, legal;

    assign opcode = ir_q[6:0];
    assign is_lw  = (opcode == OP_LW);
    assign is_sw  = (opcode == OP_SW);
    assign is_r   = (opcode == OP_R);
    assign is_i   = (opcode == OP_I);
    assign is_br  = (opcode == OP_BR);
    assign br_ok  = is_br && (ir_q[14:12] == 3'b000) && !g_ovf;
    assign legal  = is_lw || is_sw || is_r || is_i || br_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            ir_q      <= '0;
            pcsrc_q   <= 1'b0;
            imm_q     <= '0;
            neg_q     <= 1'b0;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    ir_q    <= instr;
                    state_q <= S_DECODE;
                end
                S_DECODE: begin
                    if (legal) begin
                        state_q <= S_EXEC;
                        neg_q   <= is_br && g_neg;
                        imm_q   <= is_br ? g_mag : 12'd0;
                    end else begin
                        state_q   <= S_HALT;
                        illegal_q <= 1'b1;
                    end
                end
                S_EXEC: begin
                    pcsrc_q <= is_br && zero;
                    if (is_lw || is_sw) begin
                        state_q <= S_MEM;
                    end else if (is_br) begin
                        state_q <= S_PCUPD;
                    end else begin
                        state_q <= S_WB;
                    end
                end
                S_MEM:   state_q <= is_lw ? S_WB : S_PCUPD;
                S_WB:    state_q <= S_PCUPD;
                S_PCUPD: begin
                    pcsrc_q   <= 1'b0;
                    retired_q <= retired_q + 32'd1;
                    state_q   <= S_FETCH;
                end
                S_HALT:  state_q <= S_HALT;
                default: state_q <= S_FETCH;
            endcase
        end
    end

    // Datapath enables are a pure function of registered state and opcode.
    logic in_datapath;
    assign in_datapath = (state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB);

    always_comb begin
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        alu_src    = 1'b0;
        mem_to_reg = 1'b0;
        alu_op     = ALU_ADD;
        if (in_datapath) begin
            reg_write  = (state_q == S_WB);
            mem_read   = (state_q == S_MEM) && is_lw;
            mem_write  = (state_q == S_MEM) && is_sw;
            mem_to_reg = (state_q == S_WB) && is_lw;
            alu_src    = is_lw || is_sw || is_i;
            if (is_br) begin
                alu_op = ALU_SUB;
            end else if (is_r) begin
                alu_op = ALU_RTYPE;
            end else if (is_i) begin
                alu_op = ALU_ITYPE;
            end
        end
    end

    assign state     = state_q;
    assign ir        = ir_q;
    assign pcsrc     = pcsrc_q;
    assign immediate = imm_q;
    assign negative  = neg_q;
    assign illegal   = illegal_q;
    assign retired   = retired_q;

endmodule

// File: tb/tb_unidade_controle.sv
// tb/tb_unidade_controle.sv - self-checking bench for unidade_controle
module tb_unidade_controle;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = '0;
    logic        zero = 1'b0;
    logic [3:0]  state;
    logic [31:0] ir;
    logic        pcsrc;
    logic [11:0] immediate;
    logic        negative;
    logic        reg_write, mem_read, mem_write, alu_src, mem_to_reg;
    logic [1:0]  alu_op;
    logic        illegal;
    logic [31:0] retired;

    unidade_controle dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr      (instr),
        .zero       (zero),
        .state      (state),
        .ir         (ir),
        .pcsrc      (pcsrc),
        .immediate  (immediate),
        .negative   (negative),
        .reg_write  (reg_write),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .alu_src    (alu_src),
        .mem_to_reg (mem_to_reg),
        .alu_op     (alu_op),
        .illegal    (illegal),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_retired = '0;

    localparam int C_LW = 0, C_SW = 1, C_R = 2, C_I = 3, C_BR = 4, C_ILL = 5;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic int model_offset(input logic [31:0] ins);
        int o;
        o = ins[31] * 4096 + ins[7] * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
        if (ins[31]) o = o - 8192;
        return o;
    endfunction

    function automatic int model_class(input logic [31:0] ins);
        case (ins[6:0])
            7'b0000011: return C_LW;
            7'b0100011: return C_SW;
            7'b0110011: return C_R;
            7'b0010011: return C_I;
            7'b1100011: return (ins[14:12] != 3'd0 || model_offset(ins) == -4096) ? C_ILL : C_BR;
            default:    return C_ILL;
        endcase
    endfunction

    function automatic int model_len(input int cls);
        case (cls)
            C_LW:    return 6;
            C_BR:    return 4;
            C_ILL:   return 0;
            default: return 5;
        endcase
    endfunction

    // Expected state k cycles after the instruction's FETCH began.
    function automatic logic [3:0] model_state(input int cls, input int k);
        logic [3:0] s[6];
        s = '{4'h0, 4'h1, 4'h2, 4'h0, 4'h0, 4'h0};
        case (cls)
            C_LW:  s = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h6, 4'h8};
            C_SW:  s = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0};
            C_BR:  s = '{4'h0, 4'h1, 4'h2, 4'h8, 4'h0, 4'h0};
            C_ILL: return (k < 2) ? 4'(k) : 4'hF;
            default: s = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h8, 4'h0};
        endcase
        return (k < model_len(cls)) ? s[k] : 4'h0;
    endfunction

    // {reg_write, mem_read, mem_write, alu_src, mem_to_reg, alu_op}
    function automatic logic [6:0] model_en(input int cls, input logic [3:0] st);
        logic act;
        logic [1:0] op;
        act = (st == 4'h2) || (st == 4'h4) || (st == 4'h6);
        op = (cls == C_BR) ? 2'd1 : (cls == C_R) ? 2'd2 : (cls == C_I) ? 2'd3 : 2'd0;
        if (!act || cls == C_ILL) return 7'd0;
        return {st == 4'h6, st == 4'h4 && cls == C_LW, st == 4'h4 && cls == C_SW,
                cls == C_LW || cls == C_SW || cls == C_I, st == 4'h6 && cls == C_LW, op};
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_state", state, 4'h0);
        check("rst_regs", {ir, immediate, negative, pcsrc, illegal}, '0);
        check("rst_retired", retired, 32'd0);
        check("rst_enables", {reg_write, mem_read, mem_write, alu_src, mem_to_reg, alu_op}, 7'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_retired = '0;
    endtask

    // Starts at a negedge in FETCH; ends at a negedge in FETCH (reset applied after an illegal one).
    task automatic run_instr(input logic [31:0] ins, input logic z, output int cycles,
                             output logic [11:0] imm_s, output logic neg_s, output logic pc_s,
                             output logic ill_s);
        int cls, len, off;
        logic [3:0] es;
        cls = model_class(ins);
        len = model_len(cls);
        off = model_offset(ins);
        cycles = 0;
        imm_s = '0;
        neg_s = 1'b0;
        pc_s = 1'b0;
        for (int k = 0; k < 14; k++) begin
            es = model_state(cls, k);
            check("state", state, es);
            check("enables", {reg_write, mem_read, mem_write, alu_src, mem_to_reg, alu_op}, model_en(cls, es));
            check("retired_hold", retired, exp_retired);
            check("pcsrc", pcsrc, (cls == C_BR && es == 4'h8) ? z : 1'b0);
            if (k >= 1) check("ir", ir, ins);
            if (cls != C_ILL && k >= 2) begin
                check("immediate", immediate, (cls == C_BR) ? 12'(off < 0 ? -off : off) : 12'd0);
                check("negative", negative, (cls == C_BR) && off < 0);
            end
            if (es == 4'h8) begin
                imm_s = immediate;
                neg_s = negative;
                pc_s = pcsrc;
            end
            instr = (es == 4'h0) ? ins : $urandom;
            zero = (es == 4'h2) ? z : 1'($urandom);
            @(posedge clk);
            @(negedge clk);
            cycles++;
            if (cls == C_ILL && k == 11) break;
            if (cls != C_ILL && state == 4'h0) break;
        end
        ill_s = illegal;
        if (cls == C_ILL) begin
            check("halt_hold", state, 4'hF);
            check("illegal_sticky", illegal, 1'b1);
            check("retired_halt", retired, exp_retired);
            do_reset();
        end else begin
            exp_retired = exp_retired + 32'd1;
            check("cpi", cycles, len);
            check("retired_inc", retired, exp_retired);
        end
    endtask

    typedef struct {
        logic [31:0] ins;
        logic        z;
        int          cyc;
        logic [11:0] imm;
        logic        neg;
        logic        pc;
        logic        ill;
    } vec_t;

    vec_t tab[12];

    initial begin
        int cyc;
        logic [11:0] imm_s;
        logic neg_s, pc_s, ill_s;
        logic [31:0] ins;
        int r;

        tab[0]  = '{32'h00402083, 1'b1, 6, 12'd0,    1'b0, 1'b0, 1'b0};
        tab[1]  = '{32'h00000863, 1'b1, 4, 12'd16,   1'b0, 1'b1, 1'b0};
        tab[2]  = '{32'h00000863, 1'b0, 4, 12'd16,   1'b0, 1'b0, 1'b0};
        tab[3]  = '{32'hFE000CE3, 1'b1, 4, 12'd8,    1'b1, 1'b1, 1'b0};
        tab[4]  = '{32'h0000007F, 1'b0, 0, 12'd0,    1'b0, 1'b0, 1'b1};
        tab[5]  = '{32'h00001863, 1'b1, 0, 12'd0,    1'b0, 1'b0, 1'b1};
        tab[6]  = '{32'h80000063, 1'b1, 0, 12'd0,    1'b0, 1'b0, 1'b1};
        tab[7]  = '{32'h00112223, 1'b1, 5, 12'd0,    1'b0, 1'b0, 1'b0};
        tab[8]  = '{32'h002081B3, 1'b1, 5, 12'd0,    1'b0, 1'b0, 1'b0};
        tab[9]  = '{32'h00108093, 1'b0, 5, 12'd0,    1'b0, 1'b0, 1'b0};
        tab[10] = '{32'h7E000FE3, 1'b1, 4, 12'd4094, 1'b0, 1'b1, 1'b0};
        tab[11] = '{32'h80000163, 1'b0, 4, 12'd4094, 1'b1, 1'b0, 1'b0};

        @(negedge clk);
        do_reset();

        for (int i = 0; i < 12; i++) begin
            run_instr(tab[i].ins, tab[i].z, cyc, imm_s, neg_s, pc_s, ill_s);
            check($sformatf("tab%0d_illegal", i), ill_s, tab[i].ill);
            if (!tab[i].ill) begin
                check($sformatf("tab%0d_cycles", i), cyc, tab[i].cyc);
                check($sformatf("tab%0d_imm", i), imm_s, tab[i].imm);
                check($sformatf("tab%0d_neg", i), neg_s, tab[i].neg);
                check($sformatf("tab%0d_pcsrc", i), pc_s, tab[i].pc);
            end
        end

        // Asynchronous reset landing in the MEM cycle of a store.
        instr = 32'h00112223;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("sw_mem_state", state, 4'h4);
        check("sw_mem_write", mem_write, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_state", state, 4'h0);
        check("midrst_mem_write", mem_write, 1'b0);
        check("midrst_ir", ir, 32'd0);
        check("midrst_retired", retired, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_retired = '0;
        run_instr(32'h00112223, 1'b0, cyc, imm_s, neg_s, pc_s, ill_s);

        // Counter wrap.
        force dut.retired_q = 32'hFFFF_FFFF;
        #1;
        release dut.retired_q;
        exp_retired = 32'hFFFF_FFFF;
        run_instr(32'h00108093, 1'b1, cyc, imm_s, neg_s, pc_s, ill_s);
        check("retired_wrap", retired, 32'd0);

        for (int n = 0; n < 40; n++) begin
            ins = $urandom;
            r = $urandom_range(0, 6);
            case (r)
                0: ins[6:0] = 7'b0000011;
                1: ins[6:0] = 7'b0100011;
                2: ins[6:0] = 7'b0110011;
                3: ins[6:0] = 7'b0010011;
                4: begin ins[6:0] = 7'b1100011; ins[14:12] = 3'd0; end
                5: ins[6:0] = 7'b1100011;
                default: ;
            endcase
            run_instr(ins, 1'($urandom), cyc, imm_s, neg_s, pc_s, ill_s);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

endmodule
